// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, LSB slice first; result valid N=WIDTH/CHUNK cycles after accept.
// in_ready only when idle; the result and flags hold in DONE until out_ready, so accept-to-accept is N+2 cycles minimum.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             accept, last;
  logic [CHUNK-1:0] a_sl, b_sl, s_sl;
  logic             c_out, c_msb;

  assign last = (cnt_q == CW'(N - 1));
  assign a_sl = CHUNK'(a_q >> (cnt_q * CHUNK));
  assign b_sl = CHUNK'(b_q >> (cnt_q * CHUNK));
  assign {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the MSB recovered from the MSB's own sum bit.
  assign c_msb = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CW'(i)) sum[i*CHUNK +: CHUNK] <= s_sl;
      end
      carry_q <= c_out;
      if (last) begin
        cout <= c_out;
        ovf  <= c_msb ^ c_out;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench: 16/4 adder with directed and random operations, plus an 8-bit sweep over CHUNK=8,4,2,1.
module tb_seq_chunk_adder;

  localparam int N = 4;

  typedef struct {
    logic [17:0] r;
    int          acc;
    int          stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference from signed/unsigned integer arithmetic: {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] x, input logic [15:0] y,
                                         input logic ci, input logic su);
    longint m, h, ux, uy, sx, sy, s, r;
    logic co, ov;
    m  = longint'(1) << w;
    h  = m / 2;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= h) ? ux - m : ux;
    sy = (uy >= h) ? uy - m : uy;
    if (su) begin
      s  = (ux - uy + m) % m;
      co = (ux >= uy);
      r  = sx - sy;
    end else begin
      s  = ux + uy + longint'(ci);
      co = (s >= m);
      s  = s % m;
      r  = sx + sy + longint'(ci);
    end
    ov = (r >= h) || (r < -h);
    return {ov, co, 16'(s)};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom % 5)
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  exp_t q[$];
  bit   tp_check = 1'b0;
  int   last_acc = -1;
  bit   main_done = 1'b0;

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is,
                       input bit use_exp, input logic [17:0] ex, input int st);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      in_valid = 1'($urandom);
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout: in_ready=0 required 1");
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1; a = ia; b = ib; cin = ic; sub = is;
    if (tp_check && last_acc >= 0) chk("throughput_gap", 32'(cyc + 1 - last_acc), 32'(N + 2));
    last_acc = cyc + 1;
    q.push_back('{use_exp ? ex : ref_op(16, ia, ib, ic, is), cyc + 1, st});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_outputs", 32'({ovf, cout, sum}), 32'(0));
    rst = 1'b0;

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, {1'b0, 1'b1, 16'h0000}, 3);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1, {1'b0, 1'b0, 16'hFFFE}, -1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, {1'b1, 1'b0, 16'h8000}, -1);
    issue(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1, {1'b0, 1'b0, 16'h2234}, -1);

    // Abandon an operation two cycles after its accept edge.
    issue(16'hABCD, 16'h1357, 1'b0, 1'b0, 0, '0, -1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", 32'(in_ready), 32'(1));
    chk("rst_mid_out_valid", 32'(out_valid), 32'(0));
    chk("rst_mid_outputs", 32'({ovf, cout, sum}), 32'(0));
    rst = 1'b0; in_valid = 1'b0;
    q.delete();

    // Reset wins over a simultaneous accept.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1111; rst = 1'b1;
    @(negedge clk);
    chk("rst_over_accept", 32'({in_ready, out_valid}), 32'(2'b10));
    rst = 1'b0; in_valid = 1'b0;

    for (int k = 0; k < 50; k++) issue(pick(), pick(), 1'($urandom), 1'($urandom), 0, '0, -1);

    last_acc = -1;
    tp_check = 1'b1;
    for (int k = 0; k < 6; k++) issue(pick(), pick(), 1'($urandom), 1'($urandom), 0, '0, 0);
    tp_check = 1'b0;

    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 100 && q.size() > 0; t++) @(negedge clk);
    main_done = 1'b1;
  end

  bit          active = 1'b0, expect_idle = 1'b0;
  logic [17:0] held = '0;
  int          stall = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk("idle_after_handshake", 32'({in_ready, out_valid}), 32'(2'b10));
        expect_idle = 1'b0;
      end
      if (out_valid && !active) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_out_valid: out_valid=1 required 0");
          out_ready = 1'b1;
        end else begin
          e = q.pop_front();
          chk("latency", 32'(cyc - e.acc), 32'(N));
          chk("result", 32'({ovf, cout, sum}), 32'(e.r));
          held   = {ovf, cout, sum};
          stall  = (e.stall >= 0) ? e.stall : int'($urandom_range(3, 0));
          active = 1'b1;
        end
      end else if (out_valid) begin
        chk("hold_in_done", 32'({in_ready, ovf, cout, sum}), 32'({1'b0, held}));
      end
      if (active) begin
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          active = 1'b0;
          expect_idle = 1'b1;
        end
      end else if (!out_valid) begin
        out_ready = 1'($urandom);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int SC = 8 >> g;
    localparam int SN = 8 / SC;

    logic       srst = 1'b1, siv = 1'b0, sci = 1'b0, ssu = 1'b0, sor = 1'b1;
    logic       sir, sov, sco, sof;
    logic [7:0] sa = '0, sb = '0, ssum;
    bit         sdone = 1'b0;
    exp_t       sq[$];
    exp_t       se;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(SC)) u_dut (
      .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir),
      .a(sa), .b(sb), .cin(sci), .sub(ssu),
      .out_valid(sov), .out_ready(sor),
      .sum(ssum), .cout(sco), .ovf(sof)
    );

    initial begin
      repeat (2) @(negedge clk);
      srst = 1'b0;
      for (int k = 0; k < 40; k++) begin
        int t;
        t = 0;
        @(negedge clk);
        while (!sir && t < 50) begin
          siv = 1'($urandom);
          @(negedge clk);
          t++;
        end
        if (!sir) begin
          checks++; failures++;
          $display("FAIL sweep_timeout chunk=%0d: in_ready=0 required 1", SC);
          break;
        end
        siv = 1'b1; sa = 8'($urandom); sb = 8'($urandom); sci = 1'($urandom); ssu = 1'($urandom);
        sq.push_back('{ref_op(8, {8'h00, sa}, {8'h00, sb}, sci, ssu), cyc + 1, 0});
      end
      @(negedge clk);
      siv = 1'b0;
      for (int t = 0; t < 50 && sq.size() > 0; t++) @(negedge clk);
      sdone = 1'b1;
    end

    always @(negedge clk) begin
      if (!srst && sov) begin
        if (sq.size() == 0) begin
          checks++; failures++;
          $display("FAIL sweep_spurious chunk=%0d: out_valid=1 required 0", SC);
        end else begin
          se = sq.pop_front();
          chk($sformatf("sweep_latency_c%0d", SC), 32'(cyc - se.acc), 32'(SN));
          chk($sformatf("sweep_result_c%0d", SC), 32'({sof, sco, 8'h00, ssum}), 32'({se.r[17:16], 8'h00, se.r[7:0]}));
        end
      end
    end
  end

  initial begin
    int t;
    for (t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (main_done && g_sweep[0].sdone && g_sweep[1].sdone && g_sweep[2].sdone && g_sweep[3].sdone) break;
    end
    if (t >= 20000) begin
      checks++; failures++;
      $display("FAIL completion_timeout: stimulus did not finish");
    end
    chk("main_queue_empty", 32'(q.size()), 32'(0));
    chk("sweep_queues_empty", 32'(g_sweep[0].sq.size() + g_sweep[1].sq.size() + g_sweep[2].sq.size() + g_sweep[3].sq.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
